ps2_kb_rx: RTL and testbench

//  Receives PS/2 keyboard frames from the board pins (PS2_KBCLK/PS2_KBDAT, passed through as kb_clk_i/kb_dat_i).

---
 rtl/ps2_kb_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_kb_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines, checks framing and parity,
// and buffers good scan-code bytes in a first-word fall-through FIFO with sticky error flags.
module ps2_kb_rx #(
    parameter  int CLK_FREQ   = 50000000,
    parameter  int FILTER_LEN = 8,
    parameter  int TIMEOUT_US = 200,
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          kb_clk_i,
    input  logic          kb_dat_i,
    input  logic          rd_i,
    input  logic          clr_err_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    output logic [AW:0]   count_o,
    output logic          irq_o,
    output logic          ovf_o,
    output logic          perr_o,
    output logic          ferr_o
);

    localparam int TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int FW          = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } stateType;

    stateType       stateReg, stateNext;
    logic           kbClkMeta, kbClkSync, kbDatMeta, kbDatSync;
    logic           filtClkReg, filtPrevReg;
    logic [FW-1:0]  filtCntReg;
    logic           fe;
    logic [3:0]     bitCntReg;
    logic [9:0]     frameReg;
    logic [TW-1:0]  toCntReg;
    logic           timeoutHit;
    logic           pushEn, setFerr, setPerr, setOvf;
    logic [7:0]     fifoMem [FIFO_DEPTH];
    logic [AW-1:0]  wrPtrReg, rdPtrReg;
    logic [AW:0]    countReg;
    logic           fifoFull, popEn, wrEn;
    logic [2:0]     flagSet, flagReg;

    // Two-flop synchronisers; idle level of both lines is high
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            kbClkMeta <= 1'b1;
            kbClkSync <= 1'b1;
            kbDatMeta <= 1'b1;
            kbDatSync <= 1'b1;
        end else begin
            kbClkMeta <= kb_clk_i;
            kbClkSync <= kbClkMeta;
            kbDatMeta <= kb_dat_i;
            kbDatSync <= kbDatMeta;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples of the opposite level
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            filtClkReg  <= 1'b1;
            filtPrevReg <= 1'b1;
            filtCntReg  <= '0;
        end else begin
            filtPrevReg <= filtClkReg;
            if (kbClkSync == filtClkReg) begin
                filtCntReg <= '0;
            end else if (filtCntReg == FW'(FILTER_LEN - 1)) begin
                filtClkReg <= kbClkSync;
                filtCntReg <= '0;
            end else begin
                filtCntReg <= filtCntReg + 1'b1;
            end
        end
    end

    assign fe         = filtPrevReg & ~filtClkReg;
    assign timeoutHit = (toCntReg == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (fe && !kbDatSync) begin
                    stateNext = RECV;
                end
            end
            RECV: begin
                if (fe && bitCntReg == 4'd10) begin
                    stateNext = CHECK;
                end else if (!fe && timeoutHit) begin
                    stateNext = IDLE;
                end
            end
            CHECK:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // frameReg[9] is the stop bit, frameReg[8] parity, frameReg[7:0] the byte
    always_comb begin
        pushEn  = 1'b0;
        setFerr = 1'b0;
        setPerr = 1'b0;
        case (stateReg)
            IDLE: setFerr = fe && kbDatSync;
            RECV: setFerr = !fe && timeoutHit;
            CHECK: begin
                if (!frameReg[9]) begin
                    setFerr = 1'b1;
                end else if (!(^frameReg[8:0])) begin
                    setPerr = 1'b1;
                end else begin
                    pushEn = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bitCntReg <= '0;
            frameReg  <= '0;
            toCntReg  <= '0;
        end else begin
            if (fe || stateReg != RECV) begin
                toCntReg <= '0;
            end else begin
                toCntReg <= toCntReg + 1'b1;
            end
            case (stateReg)
                IDLE: begin
                    if (fe && !kbDatSync) begin
                        bitCntReg <= 4'd1;
                    end
                end
                RECV: begin
                    if (fe) begin
                        frameReg  <= {kbDatSync, frameReg[9:1]};
                        bitCntReg <= bitCntReg + 1'b1;
                    end
                end
                default: bitCntReg <= '0;
            endcase
        end
    end

    // A push into a full FIFO still succeeds when a pop frees the head slot in the same cycle
    assign fifoFull = (countReg == (AW + 1)'(FIFO_DEPTH));
    assign popEn    = rd_i && (countReg != '0);
    assign wrEn     = pushEn && (!fifoFull || popEn);
    assign setOvf   = pushEn && fifoFull && !popEn;

    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            fifoMem[wrPtrReg] <= frameReg[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (wrEn) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (popEn) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            case ({wrEn, popEn})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    // Sticky flags: a set event outranks a simultaneous clear
    assign flagSet = {setFerr, setPerr, setOvf};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gStickyFlag
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    flagReg[gi] <= 1'b0;
                end else if (flagSet[gi]) begin
                    flagReg[gi] <= 1'b1;
                end else if (clr_err_i) begin
                    flagReg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign valid_o = (countReg != '0);
    assign data_o  = valid_o ? fifoMem[rdPtrReg] : 8'h00;
    assign count_o = countReg;
    assign irq_o   = valid_o;
    assign ovf_o   = flagReg[0];
    assign perr_o  = flagReg[1];
    assign ferr_o  = flagReg[2];

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed plus randomised bench for ps2_kb_rx; expected FIFO contents and flags come from a
// queue-based model of what each frame should do.
module tb_ps2_kb_rx;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rstN, kbClk, kbDat, rd, clrErr;
    logic [7:0] dataO;
    logic       validO, irqO, ovfO, perrO, ferrO;
    logic [4:0] countO;

    int errors = 0;
    int checks = 0;

    byte unsigned modelQ[$];
    bit           mOvf, mPerr, mFerr;

    always #5 clk = ~clk;

    // 1 MHz clock scale: one clk cycle stands for 1 us, so the timeout is 200 cycles
    ps2_kb_rx #(
        .CLK_FREQ  (1000000),
        .FILTER_LEN(8),
        .TIMEOUT_US(200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rstN),
        .kb_clk_i (kbClk),
        .kb_dat_i (kbDat),
        .rd_i     (rd),
        .clr_err_i(clrErr),
        .data_o   (dataO),
        .valid_o  (validO),
        .count_o  (countO),
        .irq_o    (irqO),
        .ovf_o    (ovfO),
        .perr_o   (perrO),
        .ferr_o   (ferrO)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".valid"}, 32'(validO), 32'(modelQ.size() != 0));
        check({tag, ".count"}, 32'(countO), 32'(modelQ.size()));
        check({tag, ".irq"},   32'(irqO),   32'(modelQ.size() != 0));
        check({tag, ".ovf"},   32'(ovfO),   32'(mOvf));
        check({tag, ".perr"},  32'(perrO),  32'(mPerr));
        check({tag, ".ferr"},  32'(ferrO),  32'(mFerr));
        if (modelQ.size() != 0) begin
            check({tag, ".data"}, 32'(dataO), 32'(modelQ[0]));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] makeFrame(input byte unsigned b, input bit badPar, input bit badStop);
        logic par;
        par = (~^b) ^ badPar;
        return {~badStop, par, b, 1'b0};
    endfunction

    // Bits are presented LSB first; data settles mid-high phase, clock low for 30 cycles
    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            kbDat = bits[i];
            cyc(15);
            kbClk = 1'b0;
            cyc(30);
            kbClk = 1'b1;
            cyc(15);
        end
        kbDat = 1'b1;
    endtask

    task automatic sendByte(input byte unsigned b, input bit badPar, input bit badStop);
        sendBits(makeFrame(b, badPar, badStop), 11);
        cyc(5);
        if (badStop) mFerr = 1'b1;
        else if (badPar) mPerr = 1'b1;
        else if (modelQ.size() < DEPTH) modelQ.push_back(b);
        else mOvf = 1'b1;
        $display("frame byte=%02h badPar=%0d badStop=%0d modelCount=%0d", b, badPar, badStop, modelQ.size());
    endtask

    task automatic popByte();
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        if (modelQ.size() != 0) void'(modelQ.pop_front());
        $display("pop modelCount=%0d", modelQ.size());
    endtask

    task automatic clearErr();
        clrErr = 1'b1;
        cyc(1);
        clrErr = 1'b0;
        mOvf = 0; mPerr = 0; mFerr = 0;
        $display("clear error flags");
    endtask

    task automatic resetPulse(input int n);
        rstN = 1'b0;
        cyc(n);
        rstN = 1'b1;
        modelQ.delete();
        mOvf = 0; mPerr = 0; mFerr = 0;
        $display("reset for %0d cycles", n);
    endtask

    initial begin
        rstN = 1'b1; kbClk = 1'b1; kbDat = 1'b1; rd = 1'b0; clrErr = 1'b0;
        cyc(1);
        resetPulse(3);
        check("reset.data", 32'(dataO), 32'h0);
        checkAll("reset");

        sendByte(8'h1C, 0, 0);
        checkAll("good1C");
        popByte();
        checkAll("good1C.pop");

        sendByte(8'h5A, 1, 0);
        checkAll("par5A");
        clearErr();
        checkAll("par5A.clr");

        sendByte(8'h33, 0, 1);
        checkAll("stop33");
        clearErr();

        for (int i = 0; i <= 16; i++) sendByte(8'(i), 0, 0);
        checkAll("fill17");
        for (int i = 0; i < 16; i++) begin
            check("drain.data", 32'(dataO), 32'(i));
            popByte();
        end
        checkAll("drained");
        popByte();
        checkAll("popEmpty");
        clearErr();

        sendBits(makeFrame(8'h77, 0, 0), 5);
        cyc(250);
        mFerr = 1'b1;
        $display("partial frame left to time out");
        checkAll("timeout");
        sendByte(8'hF0, 0, 0);
        checkAll("afterTimeout");
        popByte();
        clearErr();

        kbClk = 1'b0;
        cyc(3);
        kbClk = 1'b1;
        cyc(20);
        $display("3-cycle kb_clk glitch");
        checkAll("glitch");

        sendByte(8'h42, 0, 0);
        sendByte(8'h13, 1, 0);
        sendBits(makeFrame(8'h99, 0, 0), 5);
        resetPulse(1);
        check("midReset.data", 32'(dataO), 32'h0);
        checkAll("midReset");
        sendByte(8'h29, 0, 0);
        checkAll("afterReset");
        popByte();

        for (int i = 0; i < 12; i++) begin
            byte unsigned b;
            int kind;
            b = 8'($urandom);
            kind = $urandom_range(0, 3);
            sendByte(b, kind == 2, kind == 3);
            checkAll("rand");
            if ($urandom_range(0, 1) == 1) begin
                popByte();
                checkAll("rand.pop");
            end
            if ($urandom_range(0, 3) == 0) begin
                clearErr();
                checkAll("rand.clr");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
